// File: rtl/fft_overlap_framer_pkg.sv
// Shared types and constants for the overlapped FFT framer and the FFT wrappers.
package fft_overlap_framer_pkg;

    // Width of the log2 frame-length field on the config port.
    localparam int LOG2_W = 5;
    typedef logic [LOG2_W-1:0] fft_len_t;

    // Default frame-length limits (log2).
    localparam int MIN_LOG2_LEN_DEF = 3;
    localparam int MAX_LOG2_LEN_DEF = 10;

    // Framer state encoding; exposed on the debug port as-is.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_CFG  = 3'd2,
        ST_READ = 3'd3,
        ST_ADV  = 3'd4
    } state_t;

    // Bytes needed to hold a value of the given bit width (ceil(width/8)).
    function automatic int data_bytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/fft_framer_skid_buf.sv
// Two-entry AXI4-Stream skid buffer. The upstream side is credit based: the
// producer watches 'level' and never pushes into a full buffer unless a pop
// happens in the same cycle. Output data is held in registers, so m_data and
// m_valid stay stable while m_ready is low.
module fft_framer_skid_buf #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [1:0]       level
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             push;
    logic             pop;

    assign pop     = m_valid && m_ready;
    assign push    = s_valid && ((level != 2'd2) || pop);
    assign m_valid = (level != 2'd0);
    assign m_data  = head;

    // Head always holds the oldest entry; tail is the overflow slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (level == 2'd0) head <= s_data;
                    else               tail <= s_data;
                    level <= level + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    level <= level - 2'd1;
                end
                2'b11: begin
                    if (level == 2'd1) begin
                        head <= s_data;
                    end else begin
                        head <= tail;
                        tail <= s_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fft_overlap_framer.sv
// Converts a continuous real sample stream into overlapped FFT frames of
// runtime length N = 2^k and hop H, with one config beat ahead of each frame.
//
// Handshakes: every stream port transfers a beat on a rising edge where valid
// and ready are both high; valid never waits on ready, and once valid is high
// the data is held until the beat transfers.
module fft_overlap_framer
    import fft_overlap_framer_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int MAX_LOG2_LEN = MAX_LOG2_LEN_DEF,
    parameter int MIN_LOG2_LEN = MIN_LOG2_LEN_DEF,
    parameter int DATA_BYTES   = data_bytes(SAMPLE_WIDTH)
) (
    input  logic                      i_aclk,
    input  logic                      i_rst,
    input  logic                      i_cfg_valid,
    input  logic [LOG2_W-1:0]         i_cfg_log2_len,
    input  logic [MAX_LOG2_LEN:0]     i_cfg_hop,
    input  logic                      i_cfg_fwd,
    output logic                      o_cfg_ready,
    output logic                      o_cfg_err,
    input  logic                      i_s_tvalid,
    input  logic [SAMPLE_WIDTH-1:0]   i_s_tdata,
    output logic                      o_s_tready,
    output logic                      o_m_tvalid,
    output logic [16*DATA_BYTES-1:0]  o_m_tdata,
    output logic                      o_m_tlast,
    input  logic                      i_m_tready,
    output logic                      o_fcfg_tvalid,
    output logic                      o_fcfg_tdata,
    output logic                      o_ovf,
    output logic [15:0]               o_frame_cnt,
    output logic [2:0]                dbg_state
);

    localparam int PW    = MAX_LOG2_LEN;
    localparam int CW    = MAX_LOG2_LEN + 1;
    localparam int DEPTH = 1 << MAX_LOG2_LEN;
    localparam int HW    = DATA_BYTES * 8;

    state_t                  state, state_nx;
    logic [PW-1:0]           wp, start;
    logic [CW-1:0]           fill, len_n, hop, rd_idx, cfg_n, fill_adv;
    logic                    fwd;
    logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
    logic [SAMPLE_WIDTH-1:0] rd_data;
    logic                    rd_pending, rd_last;
    logic                    wr, cfg_fire, cfg_legal, cfg_take, issue, beat;
    logic                    skid_valid;
    logic [SAMPLE_WIDTH:0]   skid_data;
    logic [1:0]              skid_level;
    logic [2:0]              occupancy;
    logic signed [HW-1:0]    re;

    assign dbg_state   = state;
    assign cfg_n       = CW'(1) << i_cfg_log2_len;
    assign cfg_legal   = (i_cfg_log2_len >= fft_len_t'(MIN_LOG2_LEN)) &&
                         (i_cfg_log2_len <= fft_len_t'(MAX_LOG2_LEN)) &&
                         (i_cfg_hop != '0) && (i_cfg_hop <= cfg_n);
    assign o_cfg_ready = (state == ST_IDLE) || (state == ST_FILL);
    assign cfg_fire    = i_cfg_valid && o_cfg_ready;
    assign cfg_take    = cfg_fire && cfg_legal;
    assign o_s_tready  = (state != ST_IDLE) && (fill < CW'(DEPTH));
    assign wr          = i_s_tvalid && o_s_tready;
    assign beat        = skid_valid && i_m_tready;
    assign fill_adv    = fill + CW'(wr) - hop;
    // Reads in flight plus entries already buffered: the credit for new reads.
    assign occupancy   = {1'b0, skid_level} + {2'b00, rd_pending};

    // State register.
    always_ff @(posedge i_aclk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next state, config beat and read issue.
    always_comb begin
        state_nx      = state;
        o_fcfg_tvalid = 1'b0;
        o_fcfg_tdata  = 1'b0;
        issue         = 1'b0;
        unique case (state)
            ST_IDLE: if (cfg_take) state_nx = ST_FILL;
            ST_FILL: begin
                if (cfg_take)            state_nx = ST_FILL;
                else if (fill >= len_n)  state_nx = ST_CFG;
            end
            ST_CFG: begin
                o_fcfg_tvalid = 1'b1;
                o_fcfg_tdata  = fwd;
                state_nx      = ST_READ;
            end
            ST_READ: begin
                issue = (rd_idx < len_n) && (occupancy < 3'd2 + {2'b00, beat});
                if (beat && skid_data[SAMPLE_WIDTH]) state_nx = ST_ADV;
            end
            ST_ADV:  state_nx = (fill_adv >= len_n) ? ST_CFG : ST_FILL;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Write pointer, frame window, fill level and latched config.
    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            wp          <= '0;
            start       <= '0;
            fill        <= '0;
            len_n       <= '0;
            hop         <= '0;
            fwd         <= 1'b0;
            o_frame_cnt <= 16'd0;
        end else begin
            wp <= wp + PW'(wr);
            if (cfg_take) begin
                // Flush: the window restarts at the write pointer; a sample
                // written this same cycle is the first one of the new window.
                start <= wp;
                fill  <= CW'(wr);
                len_n <= cfg_n;
                hop   <= i_cfg_hop;
                fwd   <= i_cfg_fwd;
            end else if (state == ST_ADV) begin
                start       <= start + hop[PW-1:0];
                fill        <= fill_adv;
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end else begin
                fill <= fill + CW'(wr);
            end
        end
    end

    // Read sequencer: one RAM read per issue, tagged with the frame's last beat.
    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            rd_idx     <= '0;
            rd_pending <= 1'b0;
            rd_last    <= 1'b0;
        end else begin
            rd_pending <= issue;
            if (issue) begin
                rd_last <= (rd_idx == len_n - CW'(1));
                rd_idx  <= rd_idx + CW'(1);
            end
            if (state == ST_CFG) rd_idx <= '0;
        end
    end

    // Sample RAM with a one-cycle registered read.
    always_ff @(posedge i_aclk) begin
        if (wr) mem[wp] <= i_s_tdata;
        rd_data <= mem[start + rd_idx[PW-1:0]];
    end

    // Overflow and config-error pulses.
    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            o_ovf     <= 1'b0;
            o_cfg_err <= 1'b0;
        end else begin
            o_ovf     <= i_s_tvalid && !o_s_tready;
            o_cfg_err <= cfg_fire && !cfg_legal;
        end
    end

    fft_framer_skid_buf #(
        .WIDTH (SAMPLE_WIDTH + 1)
    ) u_skid (
        .clk     (i_aclk),
        .rst     (i_rst),
        .s_valid (rd_pending),
        .s_data  ({rd_last, rd_data}),
        .m_valid (skid_valid),
        .m_data  (skid_data),
        .m_ready (i_m_tready),
        .level   (skid_level)
    );

    assign re         = HW'(signed'(skid_data[SAMPLE_WIDTH-1:0]));
    assign o_m_tvalid = skid_valid;
    assign o_m_tdata  = {{HW{1'b0}}, re};
    assign o_m_tlast  = skid_valid && skid_data[SAMPLE_WIDTH];

endmodule

// File: tb/tb_fft_overlap_framer.sv
// Directed bench for fft_overlap_framer with a queue-based scoreboard.
module tb_fft_overlap_framer;
    import fft_overlap_framer_pkg::*;

    localparam int W = 33;  // {tlast, im[15:0], re[15:0]}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [4:0]  cfg_log2_len = '0;
    logic [10:0] cfg_hop = '0;
    logic        cfg_fwd = 1'b0;
    logic        cfg_ready, cfg_err;
    logic        s_tvalid = 1'b0;
    logic [15:0] s_tdata = '0;
    logic        s_tready;
    logic        m_tvalid, m_tlast;
    logic [31:0] m_tdata;
    logic        m_tready = 1'b1;
    logic        fcfg_tvalid, fcfg_tdata, ovf;
    logic [15:0] frame_cnt;
    logic [2:0]  dbg_state;

    int          vectors = 0;
    int          miscompares = 0;
    logic [W-1:0] exp_q[$];
    logic        exp_cfg_q[$];
    int          ready_mode = 0;  // 0: hold 1, 1: toggle, 2: hold 0
    bit          mon_off = 1'b0;
    bit          chk_bubble = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    fft_overlap_framer dut (
        .i_aclk         (clk),
        .i_rst          (rst),
        .i_cfg_valid    (cfg_valid),
        .i_cfg_log2_len (cfg_log2_len),
        .i_cfg_hop      (cfg_hop),
        .i_cfg_fwd      (cfg_fwd),
        .o_cfg_ready    (cfg_ready),
        .o_cfg_err      (cfg_err),
        .i_s_tvalid     (s_tvalid),
        .i_s_tdata      (s_tdata),
        .o_s_tready     (s_tready),
        .o_m_tvalid     (m_tvalid),
        .o_m_tdata      (m_tdata),
        .o_m_tlast      (m_tlast),
        .i_m_tready     (m_tready),
        .o_fcfg_tvalid  (fcfg_tvalid),
        .o_fcfg_tdata   (fcfg_tdata),
        .o_ovf          (ovf),
        .o_frame_cnt    (frame_cnt),
        .dbg_state      (dbg_state)
    );

    // Downstream ready pattern, changed just after the rising edge.
    always begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'b0;
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_tvalid = 1'b0;
        cfg_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_cfg(input int k, input int h, input logic fwd, input logic exp_err);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_log2_len = 5'(k);
        cfg_hop = 11'(h);
        cfg_fwd = fwd;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("cfg_err", cfg_err, exp_err);
    endtask

    task automatic push_samples(input int base, input int n);
        int sent = 0;
        int cyc_n = 0;
        while (sent < n && cyc_n < 4 * n + 64) begin
            @(negedge clk);
            cyc_n++;
            s_tvalid = 1'b1;
            s_tdata = 16'(base + sent);
            if (s_tready) sent++;
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        check("push_count", sent, n);
    endtask

    task automatic exp_frame(input int base, input int n, input logic fwd);
        exp_cfg_q.push_back(fwd);
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == n - 1), 16'h0000, 16'(base + i)});
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || exp_cfg_q.size() != 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("drain_beats_left", exp_q.size(), 0);
        check("drain_cfg_left", exp_cfg_q.size(), 0);
        exp_q.delete();
        exp_cfg_q.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {cfg_ready, cfg_err, s_tready, m_tvalid, m_tdata, m_tlast,
                     fcfg_tvalid, fcfg_tdata, ovf, frame_cnt}, {1'b1, 55'd0});
        check("reset_state", dbg_state, ST_IDLE);
    endtask

    // ---------------- scoreboard monitor ----------------
    int          cyc = 0;
    int          read_t0 = 0;
    logic [2:0]  prev_state = 3'd0;
    bit          prev_stall = 1'b0;
    logic [W-1:0] prev_beat = '0;
    bit          seen_valid = 1'b0;
    bit          cfg_pending = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst || mon_off) begin
            prev_stall  = 1'b0;
            seen_valid  = 1'b0;
            cfg_pending = 1'b0;
        end else begin
            if (dbg_state == ST_READ && prev_state != ST_READ) read_t0 = cyc;
            if (prev_stall)
                check("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_beat});
            if (fcfg_tvalid) begin
                if (exp_cfg_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_fcfg: got %0h expected none", fcfg_tdata);
                end else begin
                    check("fcfg_tdata", fcfg_tdata, exp_cfg_q.pop_front());
                end
                cfg_pending = 1'b1;
            end
            if (m_tvalid && !seen_valid) begin
                check("first_beat_lat", cyc - read_t0, 2);
                seen_valid = 1'b1;
            end else if (chk_bubble && seen_valid) begin
                check("no_bubble", m_tvalid, 1'b1);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got %0h expected none", {m_tlast, m_tdata});
                end else begin
                    check("beat", {m_tlast, m_tdata}, exp_q.pop_front());
                end
                check("cfg_before_data", cfg_pending, 1'b1);
                if (m_tlast) begin
                    cfg_pending = 1'b0;
                    seen_valid  = 1'b0;
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = {m_tlast, m_tdata};
        end
        prev_state = dbg_state;
    end

    // ---------------- directed tests ----------------
    initial begin
        int sent;
        int ovf_n;
        int c;

        // Reset values.
        do_reset();
        check_reset_outputs("reset_outputs");

        // Contiguous frames: k=3, H=8, fwd=1, ramp 0..31.
        chk_bubble = 1'b1;
        send_cfg(3, 8, 1'b1, 1'b0);
        for (int f = 0; f < 4; f++) exp_frame(8 * f, 8, 1'b1);
        push_samples(0, 32);
        wait_drain(200);
        check("frame_cnt_contig", frame_cnt, 16'd4);
        check("state_after_contig", dbg_state, ST_FILL);

        // Overlapped frames: k=3, H=4, fwd=0, ramp 0..15.
        do_reset();
        send_cfg(3, 4, 1'b0, 1'b0);
        exp_frame(0, 8, 1'b0);
        exp_frame(4, 8, 1'b0);
        exp_frame(8, 8, 1'b0);
        push_samples(0, 16);
        wait_drain(200);
        check("frame_cnt_overlap", frame_cnt, 16'd3);
        chk_bubble = 1'b0;

        // Backpressure: k=4, H=16, toggling ready, negative samples -8..7.
        do_reset();
        ready_mode = 1;
        send_cfg(4, 16, 1'b1, 1'b0);
        exp_frame(-8, 16, 1'b1);
        push_samples(-8, 16);
        wait_drain(300);
        check("frame_cnt_bp", frame_cnt, 16'd1);
        ready_mode = 0;

        // Illegal configs are rejected and leave the framer idle.
        do_reset();
        send_cfg(2, 4, 1'b1, 1'b1);
        check("illegal_k2_state", dbg_state, ST_IDLE);
        send_cfg(11, 8, 1'b1, 1'b1);
        check("illegal_k11_state", dbg_state, ST_IDLE);
        send_cfg(3, 0, 1'b1, 1'b1);
        check("illegal_h0_tready", s_tready, 1'b0);
        send_cfg(3, 9, 1'b1, 1'b1);
        check("illegal_h9_tready", s_tready, 1'b0);
        check("illegal_cfg_ready", cfg_ready, 1'b1);
        @(negedge clk);
        check("cfg_err_clear", cfg_err, 1'b0);

        // Full buffer: k=10, H=1024, downstream stalled, continuous source.
        do_reset();
        ready_mode = 2;
        send_cfg(10, 1024, 1'b1, 1'b0);
        exp_frame(0, 1024, 1'b1);
        sent = 0;
        ovf_n = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (ovf) ovf_n++;
            s_tvalid = 1'b1;
            s_tdata = 16'(sent);
            if (s_tready) sent++;
        end
        @(negedge clk);
        if (ovf) ovf_n++;
        s_tvalid = 1'b0;
        @(negedge clk);
        check("full_accepted", sent, 1024);
        check("full_ovf_pulses", ovf_n, 1100 - 1024);
        check("full_ovf_clear", ovf, 1'b0);
        check("full_tready_low", s_tready, 1'b0);
        ready_mode = 0;
        wait_drain(1300);
        check("frame_cnt_full", frame_cnt, 16'd1);
        check("state_after_full", dbg_state, ST_FILL);

        // Reset on beat 5 of a k=3 frame, then a clean restart.
        do_reset();
        send_cfg(3, 8, 1'b1, 1'b0);
        exp_cfg_q.push_back(1'b1);
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, 16'h0000, 16'(i)});
        push_samples(0, 8);
        c = 0;
        while (exp_q.size() != 0 && c < 100) begin
            @(posedge clk);
            c++;
        end
        check("pre_reset_beats_left", exp_q.size(), 0);
        #2;
        mon_off = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midframe_reset_outputs");
        rst = 1'b0;
        mon_off = 1'b0;
        exp_q.delete();
        exp_cfg_q.delete();
        send_cfg(3, 8, 1'b0, 1'b0);
        exp_frame(100, 8, 1'b0);
        push_samples(100, 8);
        wait_drain(200);
        check("frame_cnt_restart", frame_cnt, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
